// File: rtl/riscv_data_mem_ctrl_if.sv
// Load/store request and response channels between the core LSU and the data memory controller.
// The master drives requests and accepts responses; the slave is the controller.
interface riscv_data_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    modport master (
        output req_valid, req_addr, req_we, req_wdata, req_funct3, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata, req_funct3, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );
endinterface

// File: rtl/riscv_data_mem_ctrl.sv
// RV32 data memory with byte-lane stores, sign/zero-extended loads and fault reporting.
// Latency: resp_valid registered LATENCY edges after the accept edge (accept, WAIT..., COMMIT, RESP).
// Backpressure: one access in flight; req_ready stays low until the response handshake completes.
module riscv_data_mem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    riscv_data_mem_ctrl_if.slave bus
);
    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, COMMIT, RESP} state_t;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [1:0]    lane;
        logic          we;
        logic [31:0]   wdata;
        logic [2:0]    funct3;
        logic          fault;
    } req_t;

    logic [31:0] mem [DEPTH_WORDS];

    state_t      state;
    req_t        cap;
    logic [3:0]  cnt;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] rdata_q;
    logic        fault_q;

    logic        illegal, misal, oor;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ld_data;
    logic        wr_en;

    // Fault classification is evaluated on the live request so it can be captured at accept.
    always_comb begin
        illegal = bus.req_we ? (bus.req_funct3 > 3'd2)
                             : (bus.req_funct3 == 3'd3 || bus.req_funct3 == 3'd6 || bus.req_funct3 == 3'd7);
        case (bus.req_funct3[1:0])
            2'b01:   misal = bus.req_addr[0];
            2'b10:   misal = (bus.req_addr[1:0] != 2'b00);
            default: misal = 1'b0;
        endcase
        oor = ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH_WORDS));
    end

    always_comb begin
        be = 4'b1111;
        wd = cap.wdata;
        case (cap.funct3[1:0])
            2'b00: begin
                be = 4'b0001 << cap.lane;
                wd = {4{cap.wdata[7:0]}};
            end
            2'b01: begin
                be = 4'b0011 << {cap.lane[1], 1'b0};
                wd = {2{cap.wdata[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = cap.wdata;
            end
        endcase
    end

    always_comb begin
        word     = mem[cap.idx];
        byte_sel = word[{cap.lane, 3'b000} +: 8];
        half_sel = word[{cap.lane[1], 4'b0000} +: 16];
        case (cap.funct3)
            3'd0:    ld_data = {{24{byte_sel[7]}}, byte_sel};
            3'd1:    ld_data = {{16{half_sel[15]}}, half_sel};
            3'd2:    ld_data = word;
            3'd4:    ld_data = {24'h000000, byte_sel};
            3'd5:    ld_data = {16'h0000, half_sel};
            default: ld_data = 32'h0;
        endcase
    end

    assign wr_en = (state == COMMIT) && cap.we && !cap.fault;

    // Storage has no reset; writes happen only in COMMIT, so a reset during WAIT leaves memory intact.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[cap.idx][8*b +: 8] <= wd[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cap          <= '0;
            cnt          <= 4'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'h0;
            fault_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        cap.idx     <= bus.req_addr[IW+1:2];
                        cap.lane    <= bus.req_addr[1:0];
                        cap.we      <= bus.req_we;
                        cap.wdata   <= bus.req_wdata;
                        cap.funct3  <= bus.req_funct3;
                        cap.fault   <= illegal | misal | oor;
                        req_ready_q <= 1'b0;
                        if (LATENCY > 1) begin
                            state <= WAIT;
                            cnt   <= 4'(LATENCY - 1);
                        end else begin
                            state <= COMMIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= COMMIT;
                end
                COMMIT: begin
                    rdata_q      <= (cap.fault || cap.we) ? 32'h0 : ld_data;
                    fault_q      <= cap.fault;
                    resp_valid_q <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        rdata_q      <= 32'h0;
                        fault_q      <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_fault = fault_q;
endmodule

// File: tb/tb_riscv_data_mem_ctrl.sv
// Scoreboard bench for riscv_data_mem_ctrl: two instances (LATENCY 1 and 4) behind one shared driver,
// selected by sel; expected responses are queued at accept and checked at the response handshake.
module tb_riscv_data_mem_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        sel;
    logic        req_valid, req_we, resp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        req_ready, resp_valid, resp_fault;
    logic [31:0] resp_rdata;

    riscv_data_mem_ctrl_if if1 ();
    riscv_data_mem_ctrl_if if4 ();

    assign if1.req_valid  = req_valid & ~sel;
    assign if4.req_valid  = req_valid & sel;
    assign if1.req_addr   = req_addr;
    assign if4.req_addr   = req_addr;
    assign if1.req_we     = req_we;
    assign if4.req_we     = req_we;
    assign if1.req_wdata  = req_wdata;
    assign if4.req_wdata  = req_wdata;
    assign if1.req_funct3 = req_funct3;
    assign if4.req_funct3 = req_funct3;
    assign if1.resp_ready = resp_ready;
    assign if4.resp_ready = resp_ready;

    assign req_ready  = sel ? if4.req_ready  : if1.req_ready;
    assign resp_valid = sel ? if4.resp_valid : if1.resp_valid;
    assign resp_rdata = sel ? if4.resp_rdata : if1.resp_rdata;
    assign resp_fault = sel ? if4.resp_fault : if1.resp_fault;

    riscv_data_mem_ctrl #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    riscv_data_mem_ctrl #(.DEPTH_WORDS(1024), .LATENCY(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   last_acc = 0;
    bit   seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Edge counts are inclusive of the accept edge: response edge number minus accept edge number plus one.
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else if (resp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'(resp_valid), 32'd0);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    chk("latency_edges", 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat + 1));
                end else if (!resp_ready) begin
                    chk("hold_rdata", resp_rdata, sb[0].rdata);
                    chk("hold_fault", 32'(resp_fault), 32'(sb[0].fault));
                    chk("hold_req_ready", 32'(req_ready), 32'd0);
                end
                if (resp_ready) begin
                    chk("rdata", resp_rdata, sb[0].rdata);
                    chk("fault", 32'(resp_fault), 32'(sb[0].fault));
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 right after the response handshake edge.
    task automatic access(input bit s, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] er, input bit ef, input int hold);
        int n;
        exp_t e;
        sel        = s;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        resp_ready = (hold == 0);
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        e.rdata = er;
        e.fault = ef;
        e.acc   = cyc + 1;
        e.lat   = s ? 4 : 1;
        last_acc = e.acc;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_we     = ~we;
        req_funct3 = 3'($urandom_range(0, 7));
        if (hold > 0) begin
            n = 0;
            while (!resp_valid && n < 30) begin
                @(posedge clk); #1;
                n++;
            end
            for (int i = 0; i < hold; i++) begin
                req_valid = (i == 2);
                @(posedge clk); #1;
            end
            req_valid  = 1'b0;
            resp_ready = 1'b1;
        end
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb.size() != 0) begin
            chk("resp_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    int a1, a2;

    initial begin
        rst = 1'b1;
        sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; resp_ready = 1'b1;
        req_addr = 32'h0; req_wdata = 32'h0; req_funct3 = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready1",  32'(if1.req_ready), 32'd1);
        chk("rst_resp_valid1", 32'(if1.resp_valid), 32'd0);
        chk("rst_rdata1",      if1.resp_rdata, 32'h0);
        chk("rst_fault1",      32'(if1.resp_fault), 32'd0);
        chk("rst_req_ready4",  32'(if4.req_ready), 32'd1);
        chk("rst_resp_valid4", 32'(if4.resp_valid), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // LATENCY=1: word store/load and back-to-back throughput.
        access(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
        a1 = last_acc;
        access(0, 0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
        a2 = last_acc;
        chk("throughput_l1", 32'(a2 - a1 + 1), 32'd4);
        // Byte store and extended byte loads.
        access(0, 1, 3'd0, 32'h13, 32'h00000080, 32'h0, 0, 0);
        access(0, 0, 3'd0, 32'h13, 32'h0, 32'hFFFFFF80, 0, 0);
        access(0, 0, 3'd4, 32'h13, 32'h0, 32'h00000080, 0, 0);
        access(0, 0, 3'd2, 32'h10, 32'h0, 32'h80ADBEEF, 0, 0);
        // Half store, misaligned half load and misaligned word store.
        access(0, 1, 3'd1, 32'h12, 32'hFFFF1234, 32'h0, 0, 0);
        access(0, 0, 3'd5, 32'h12, 32'h0, 32'h00001234, 0, 0);
        access(0, 0, 3'd1, 32'h11, 32'h0, 32'h0, 1, 0);
        access(0, 1, 3'd2, 32'h12, 32'h55555555, 32'h0, 1, 0);
        access(0, 0, 3'd2, 32'h10, 32'h0, 32'h1234BEEF, 0, 0);
        access(0, 0, 3'd1, 32'h10, 32'h0, 32'hFFFFBEEF, 0, 0);
        // Range edges and illegal funct3.
        access(0, 0, 3'd2, 32'h1000, 32'h0, 32'h0, 1, 0);
        access(0, 1, 3'd2, 32'hFFFFFFFC, 32'h77777777, 32'h0, 1, 0);
        access(0, 1, 3'd2, 32'hFFC, 32'hAB000055, 32'h0, 0, 0);
        access(0, 0, 3'd2, 32'hFFC, 32'h0, 32'hAB000055, 0, 0);
        access(0, 0, 3'd4, 32'hFFF, 32'h0, 32'h000000AB, 0, 0);
        access(0, 0, 3'd3, 32'h0, 32'h0, 32'h0, 1, 0);
        access(0, 1, 3'd3, 32'h10, 32'h0, 32'h0, 1, 0);
        access(0, 0, 3'd2, 32'h10, 32'h0, 32'h1234BEEF, 0, 0);
        // Response held off for 5 cycles with a stray request pulse.
        access(0, 0, 3'd2, 32'h10, 32'h0, 32'h1234BEEF, 0, 5);

        // LATENCY=4.
        access(1, 1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
        a1 = last_acc;
        access(1, 0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
        a2 = last_acc;
        chk("throughput_l4", 32'(a2 - a1 + 1), 32'd7);
        access(1, 1, 3'd2, 32'h20, 32'h11111111, 32'h0, 0, 0);

        // Reset in the second WAIT cycle abandons the store.
        sel = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
        req_valid = 1'b1;
        chk("t6_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_req_ready",  32'(req_ready), 32'd1);
        chk("t6_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("t6_rst_rdata",      resp_rdata, 32'h0);
        chk("t6_rst_fault",      32'(resp_fault), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        access(1, 0, 3'd2, 32'h20, 32'h0, 32'h11111111, 0, 0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
